// File: rtl/add_seq_ctrl.sv
// Wide add/subtract sequencer: one WIDTH-bit ripple adder is reused once per
// chunk, LSB chunk first, with operand/result shift registers and a carry flop.

module add #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);
  logic [WIDTH:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[WIDTH];
endmodule

module add_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int WORDS = 4,
  localparam int N    = WIDTH * WORDS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic         in_sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_s,
  output logic         out_cout,
  output logic         out_ovf,
  output logic         out_zero
);
  localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic [N-1:0]   res_q, res_d;
  logic           carry_q, carry_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           a_msb_q, a_msb_d;
  logic           b_msb_q, b_msb_d;
  logic           in_ready_q, in_ready_d;
  logic           out_valid_q, out_valid_d;
  logic [N-1:0]   out_s_q, out_s_d;
  logic           out_cout_q, out_cout_d;
  logic           out_ovf_q, out_ovf_d;
  logic           out_zero_q, out_zero_d;

  logic [N-1:0]       b_eff;
  logic [WIDTH-1:0]   sum;
  logic               sum_cout;
  logic [N+WIDTH-1:0] res_ext;
  logic [N-1:0]       res_shift;

  // Operands shift right so the active chunk is always at the bottom.
  add #(.WIDTH(WIDTH)) u_add (
    .a   (a_q[WIDTH-1:0]),
    .b   (b_q[WIDTH-1:0]),
    .cin (carry_q),
    .s   (sum),
    .cout(sum_cout)
  );

  assign b_eff     = in_sub ? ~in_b : in_b;
  // New sum chunk enters at the top; after WORDS shifts chunk 0 sits at the LSB.
  assign res_ext   = {sum, res_q};
  assign res_shift = res_ext[N+WIDTH-1:WIDTH];

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    a_msb_d     = a_msb_q;
    b_msb_d     = b_msb_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_s_d     = out_s_q;
    out_cout_d  = out_cout_q;
    out_ovf_d   = out_ovf_q;
    out_zero_d  = out_zero_q;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d        = in_a;
          b_d        = b_eff;
          carry_d    = in_sub;
          cnt_d      = '0;
          a_msb_d    = in_a[N-1];
          b_msb_d    = b_eff[N-1];
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> WIDTH;
        b_d     = b_q >> WIDTH;
        res_d   = res_shift;
        carry_d = sum_cout;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          cnt_d       = '0;
          out_valid_d = 1'b1;
          out_s_d     = res_shift;
          out_cout_d  = sum_cout;
          out_ovf_d   = (a_msb_q == b_msb_q) && (res_shift[N-1] != a_msb_q);
          out_zero_d  = (res_shift == '0);
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_s_q     <= '0;
      out_cout_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      a_msb_q     <= a_msb_d;
      b_msb_q     <= b_msb_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_s_q     <= out_s_d;
      out_cout_q  <= out_cout_d;
      out_ovf_q   <= out_ovf_d;
      out_zero_q  <= out_zero_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_s     = out_s_q;
  assign out_cout  = out_cout_q;
  assign out_ovf   = out_ovf_q;
  assign out_zero  = out_zero_q;
endmodule

// File: tb/tb_add_seq_ctrl.sv
// Scoreboard bench for add_seq_ctrl (WIDTH=4, WORDS=4): directed corner cases
// followed by randomized traffic with random in_valid/out_ready.

module tb_add_seq_ctrl;
  localparam int W  = 4;
  localparam int WD = 4;
  localparam int N  = W * WD;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic         in_sub;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_s;
  logic         out_cout;
  logic         out_ovf;
  logic         out_zero;

  add_seq_ctrl #(.WIDTH(W), .WORDS(WD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_sub   (in_sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_s    (out_s),
    .out_cout (out_cout),
    .out_ovf  (out_ovf),
    .out_zero (out_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] s;
    logic         c;
    logic         o;
    logic         z;
    int           acc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   n_acc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain unsigned/signed integer arithmetic on whole operands.
  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                 input logic sub, input int acc);
    exp_t e;
    int ua, ub, sa, sb, u, r;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    u  = sub ? ua - ub : ua + ub;
    r  = sub ? sa - sb : sa + sb;
    e.s   = u[N-1:0];
    e.c   = sub ? (ua >= ub) : (u > 65535);
    e.o   = (r > 32767) || (r < -32768);
    e.z   = (e.s == '0);
    e.acc = acc;
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Stimulus side of the scoreboard: record every accepted operation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && in_valid && in_ready) begin
      q.push_back(model(in_a, in_b, in_sub, cyc));
      n_acc++;
    end
  end

  // Monitor: latency, stability under backpressure, and result comparison.
  logic         pv  = 1'b0;
  logic         phs = 1'b0;
  logic [N-1:0] ps;
  logic [2:0]   pf;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1) begin
      if (out_valid && !pv && q.size() > 0)
        chk("latency", 32'(cyc - (q[0].acc + 1)), 32'(WD));
      if (pv && !phs) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", {13'd0, out_cout, out_ovf, out_zero, out_s}, {13'd0, pf, ps});
      end
      if (out_valid) chk("in_ready_in_done", 32'(in_ready), 32'd0);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_result", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("out_s", 32'(out_s), 32'(e.s));
          chk("out_cout", 32'(out_cout), 32'(e.c));
          chk("out_ovf", 32'(out_ovf), 32'(e.o));
          chk("out_zero", 32'(out_zero), 32'(e.z));
        end
      end
      pv  = out_valid;
      phs = out_valid && out_ready;
      ps  = out_s;
      pf  = {out_cout, out_ovf, out_zero};
    end else begin
      pv  = 1'b0;
      phs = 1'b0;
    end
  end

  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub);
    int n = 0;
    in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) chk("accept_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    if (n >= 20) chk("out_timeout", 32'd1, 32'd0);
  endtask

  task automatic dir_op(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic sub, input logic [N-1:0] es, input logic ec,
                        input logic eo, input logic ez);
    int n;
    issue(a, b, sub);
    wait_out(n);
    chk({name, "_lat"}, 32'(n), 32'(WD));
    chk({name, "_s"}, 32'(out_s), 32'(es));
    chk({name, "_flags"}, {29'd0, out_cout, out_ovf, out_zero}, {29'd0, ec, eo, ez});
    @(posedge clk); #1;
    chk({name, "_ready_back"}, {30'd0, in_ready, out_valid}, 32'b10);
  endtask

  function automatic logic [N-1:0] rval();
    case ($urandom % 6)
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h7FFF;
      3: return 16'h8000;
      default: return N'($urandom);
    endcase
  endfunction

  initial begin
    int n;
    int lim;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {26'd0, in_ready, out_valid, out_cout, out_ovf, out_zero, 1'b0},
        {26'd0, 6'b100000});
    chk("reset_out_s", 32'(out_s), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    dir_op("add_ff_1", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
    dir_op("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    dir_op("sub_borrow", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    dir_op("sub_ovf", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);

    // Backpressure: result must hold and new requests must be refused.
    out_ready = 1'b0;
    issue(16'h7FFF, 16'h0001, 1'b0);
    wait_out(n);
    chk("bp_lat", 32'(n), 32'(WD));
    in_a = 16'hAAAA; in_b = 16'h5555; in_sub = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_s", 32'(out_s), 32'h8000);
      chk("bp_flags", {28'd0, out_valid, out_cout, out_ovf, out_zero}, {28'd0, 4'b1010});
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", {30'd0, in_ready, out_valid}, 32'b10);

    // Reset during the second RUN cycle discards the operation.
    issue(16'h4321, 16'h1111, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_ctl", {30'd0, in_ready, out_valid}, 32'b10);
    chk("midrst_out", {13'd0, out_cout, out_ovf, out_zero, out_s}, 32'd0);
    dir_op("after_rst", 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0);

    // Random traffic.
    n_acc = 0;
    lim   = 0;
    while (n_acc < 1000 && lim < 40000) begin
      in_valid  = ($urandom % 2) == 0;
      in_a      = rval();
      in_b      = rval();
      in_sub    = $urandom % 2;
      out_ready = ($urandom % 10) < 7;
      @(posedge clk); #1;
      lim++;
    end
    chk("random_ops_done", 32'(n_acc >= 1000), 32'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    lim = 0;
    while ((q.size() != 0 || out_valid) && lim < 50) begin @(posedge clk); #1; lim++; end
    chk("drain_empty", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
